// File: rtl/mul_accum.sv
// Product accumulator: sums up to N unsigned 8-bit products per group with
// saturation, then holds the result until the consumer takes it.
module mul_accum #(
    parameter int N     = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       prod_in,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic [8:0]       sum_cnt,
    output logic             sat
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [8:0]       cnt;
    logic             sat_q;

    logic [ACC_W:0]   sum_wide;
    logic             ovf;
    logic [ACC_W-1:0] acc_nxt;
    logic             accept;
    logic             done;

    // One spare bit catches the carry; a carry means clamp to all-ones.
    assign sum_wide = {1'b0, acc} + {{(ACC_W-7){1'b0}}, prod_in};
    assign ovf      = sum_wide[ACC_W];
    assign acc_nxt  = ovf ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    assign accept   = in_valid && in_ready;
    assign done     = accept && ((cnt == 9'(N-1)) || in_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat_q     <= 1'b0;
            sum_out   <= '0;
            sum_cnt   <= '0;
            sat       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (clr) begin
            // Result registers are left alone; they are don't-care once out_valid drops.
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat_q     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (state == ACCUM) begin
            if (done) begin
                sum_out   <= acc_nxt;
                sum_cnt   <= cnt + 9'd1;
                sat       <= sat_q | ovf;
                acc       <= '0;
                cnt       <= '0;
                sat_q     <= 1'b0;
                state     <= HOLD;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
            end else if (accept) begin
                acc   <= acc_nxt;
                cnt   <= cnt + 9'd1;
                sat_q <= sat_q | ovf;
            end
        end else if (out_ready) begin
            // Accumulator was already cleared at load, so ACCUM is ready next cycle.
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mul_accum.md
MUL_ACCUM -- requirements
Module: mul_accum

Interface
REQ-001 Parameter N, default 8, SHALL set the products per accumulation; legal range 2..256.
REQ-002 Parameter ACC_W, default 16, SHALL set the accumulator and sum width; legal range 8..32.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 clr  input  1  synchronous abort of the current accumulation.
REQ-007 in_valid  input  1  prod_in holds a valid product.
REQ-008 prod_in  input  8  unsigned product from the upstream 4x4 multiplier.
REQ-009 in_last  input  1  qualifies the current product as the final one of a group shorter than N.
REQ-010 in_ready  output  1  block accepts a product this cycle.
REQ-011 out_valid  output  1  sum_out holds a completed sum.
REQ-012 out_ready  input  1  consumer accepts sum_out this cycle.
REQ-013 sum_out  output  ACC_W  accumulated unsigned sum.
REQ-014 sum_cnt  output  9  number of products in sum_out, 1..N.
REQ-015 sat  output  1  sum_out was clamped during this group.

Function
REQ-016 The block SHALL have two states: ACCUM and HOLD.
REQ-017 in_ready SHALL be 1 in ACCUM and 0 in HOLD; out_valid SHALL be 1 exactly in HOLD.
REQ-018 A product SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-019 On acceptance, the accumulator SHALL add zero-extended prod_in, and the count SHALL increment.
REQ-020 The add SHALL saturate at 2^ACC_W-1; saturation SHALL set the internal sat flag for the group.
REQ-021 An acceptance with count==N-1 or in_last==1 SHALL move to HOLD at that edge.
REQ-022 At that same edge, the sum including that product SHALL be loaded into sum_out, with sum_cnt and sat.
REQ-023 Latency: the final product accepted at edge k SHALL give out_valid=1 with the final sum after edge k.
REQ-024 In HOLD, sum_out, sum_cnt and sat SHALL be stable until the handshake completes.
REQ-025 In HOLD, an edge with out_ready==1 SHALL return to ACCUM with accumulator, count and sat flag cleared.
REQ-026 After that return, the next cycle SHALL have in_ready=1, giving zero bubble from the downstream side.
REQ-027 in_valid==0 in ACCUM SHALL hold all state.
REQ-028 in_last SHALL be ignored when in_valid or in_ready is 0.
REQ-029 clr==1 at an edge SHALL clear accumulator, count and sat flag and force ACCUM, from either state.
REQ-030 clr SHALL drop a pending sum in HOLD and ignore any simultaneous product.
REQ-031 clr SHALL NOT alter sum_out or sum_cnt; their values are don't-care when out_valid==0.
REQ-032 When count==N-1 and in_last==1 arrive together, the block SHALL perform a single transition to HOLD with sum_cnt=N.
REQ-033 The count SHALL never wrap; N products always force HOLD.

Reset
REQ-034 rst==1 SHALL immediately force ACCUM and clear the accumulator and count.
REQ-035 rst==1 SHALL immediately set sum_out=0, sum_cnt=0, sat=0, out_valid=0 and in_ready=1.
REQ-036 rst asserted mid-group SHALL discard all partial data; the first product after release starts a new group.

Verification
REQ-037 N=8: eight products of 225, one per cycle, out_ready=1 -> out_valid one cycle after the 8th; sum_out=1800, sum_cnt=8, sat=0.
REQ-038 Products 3, 5, then 7 with in_last=1 -> sum_out=15, sum_cnt=3; the next group's product 2 is accepted the cycle after the handshake.
REQ-039 out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0; sum_out stable; no product lost after out_ready rises.
REQ-040 ACC_W=8, N=4: products 200 and 100 with in_last -> sum_out=255, sat=1; next group with product 1 -> sat=0.
REQ-041 clr pulsed after 4 products, and clr again during HOLD -> out_valid drops; a following group of 10 and 20 (in_last) gives sum_out=30, sum_cnt=2.
REQ-042 rst asserted asynchronously mid-cycle after 3 products -> outputs at reset values before the next edge; a fresh N=8 group of 1s gives sum_out=8.
